// File: rtl/prog_clk_div_if.sv
// Control/status bundle of the programmable clock divider.
// Latency: none (wires only).
// Backpressure: config port is valid/ready; o_cfg_ready drops while a config is pending.
interface prog_clk_div_if #(
    parameter int CNT_WID = 16
) ();
    logic               i_ce;
    logic               i_cfg_valid;
    logic               o_cfg_ready;
    logic [CNT_WID-1:0] i_cfg_period;
    logic [CNT_WID-1:0] i_cfg_high;
    logic               i_sync;
    logic               o_clk;
    logic               o_rise_stb;
    logic               o_fall_stb;
    logic               o_cfg_err;

    modport master (
        output i_ce, i_cfg_valid, i_cfg_period, i_cfg_high, i_sync,
        input  o_cfg_ready, o_clk, o_rise_stb, o_fall_stb, o_cfg_err
    );

    modport slave (
        input  i_ce, i_cfg_valid, i_cfg_period, i_cfg_high, i_sync,
        output o_cfg_ready, o_clk, o_rise_stb, o_fall_stb, o_cfg_err
    );
endinterface

// File: rtl/prog_clk_div.sv
// Runtime-programmable integer divider producing a registered logic-domain clock plus edge strobes.
// Latency: all outputs registered, one i_clk cycle after the causing edge.
// Backpressure: one-deep config slot; o_cfg_ready low from accept until applied at a period boundary.
module prog_clk_div #(
    parameter int CNT_WID        = 16,
    parameter int DEFAULT_PERIOD = 8,
    parameter int DEFAULT_HIGH   = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    prog_clk_div_if.slave io_bus
);
    typedef enum logic [1:0] {
        ST_RESET = 2'b00,
        ST_RUN   = 2'b01,
        ST_IDLE  = 2'b10
    } state_t;

    localparam logic [CNT_WID-1:0] DEF_PER  = CNT_WID'(DEFAULT_PERIOD);
    localparam logic [CNT_WID-1:0] DEF_HIGH = CNT_WID'(DEFAULT_HIGH);
    localparam logic [CNT_WID-1:0] MIN_PER  = CNT_WID'(2);

    state_t             r_state;
    logic [CNT_WID-1:0] r_cnt;
    logic [CNT_WID-1:0] r_per_act;
    logic [CNT_WID-1:0] r_high_act;
    logic               r_pend_vld;
    logic [CNT_WID-1:0] r_pend_per;
    logic [CNT_WID-1:0] r_pend_high;
    logic               r_clk;
    logic               r_rise;
    logic               r_fall;
    logic               r_err;

    state_t             w_state_nxt;
    logic [CNT_WID-1:0] w_cnt_nxt;
    logic [CNT_WID-1:0] w_per_nxt;
    logic [CNT_WID-1:0] w_high_nxt;
    logic               w_pend_vld_nxt;
    logic               w_clk_nxt;
    logic               w_adv;
    logic               w_bound;
    logic               w_wrap;
    logic               w_xfer;
    logic               w_bad;

    // Config acceptance is independent of i_ce so a paused divider can still be reprogrammed.
    assign w_xfer = io_bus.i_cfg_valid && !r_pend_vld;
    assign w_bad  = (io_bus.i_cfg_period < MIN_PER) || (io_bus.i_cfg_high > io_bus.i_cfg_period);
    assign w_wrap = (r_cnt == r_per_act - 1'b1);

    // Next-state, counter, boundary config swap and the clock level that goes with the new count.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_per_nxt      = r_per_act;
        w_high_nxt     = r_high_act;
        w_pend_vld_nxt = r_pend_vld;
        w_clk_nxt      = r_clk;
        w_adv          = 1'b0;
        w_bound        = 1'b0;
        case (r_state)
            ST_RESET: begin
                if (io_bus.i_ce) begin
                    w_state_nxt = ST_RUN;
                    w_adv       = 1'b1;
                    w_bound     = 1'b1;
                end
            end
            ST_RUN: begin
                if (!io_bus.i_ce) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_adv   = 1'b1;
                    w_bound = io_bus.i_sync || w_wrap;
                end
            end
            ST_IDLE: begin
                // Sync is not honoured on the resume edge; only a natural wrap is a boundary here.
                if (io_bus.i_ce) begin
                    w_state_nxt = ST_RUN;
                    w_adv       = 1'b1;
                    w_bound     = w_wrap;
                end
            end
            default: w_state_nxt = ST_RESET;
        endcase

        if (w_adv) begin
            w_cnt_nxt = w_bound ? '0 : r_cnt + 1'b1;
        end
        // Only a config that was already pending before this edge can be applied on it.
        if (w_bound && r_pend_vld) begin
            w_per_nxt      = r_pend_per;
            w_high_nxt     = r_pend_high;
            w_pend_vld_nxt = 1'b0;
        end else if (w_xfer && !w_bad) begin
            w_pend_vld_nxt = 1'b1;
        end
        if (w_adv) begin
            w_clk_nxt = (w_cnt_nxt < w_high_nxt);
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath, pending slot and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt       <= '0;
            r_per_act   <= DEF_PER;
            r_high_act  <= DEF_HIGH;
            r_pend_vld  <= 1'b0;
            r_pend_per  <= '0;
            r_pend_high <= '0;
            r_clk       <= 1'b0;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_per_act  <= w_per_nxt;
            r_high_act <= w_high_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            if (w_xfer && !w_bad) begin
                r_pend_per  <= io_bus.i_cfg_period;
                r_pend_high <= io_bus.i_cfg_high;
            end
            r_clk  <= w_clk_nxt;
            r_rise <= w_adv && w_clk_nxt && !r_clk;
            r_fall <= w_adv && !w_clk_nxt && r_clk;
            r_err  <= w_xfer && w_bad;
        end
    end

    assign io_bus.o_cfg_ready = !r_pend_vld;
    assign io_bus.o_clk       = r_clk;
    assign io_bus.o_rise_stb  = r_rise;
    assign io_bus.o_fall_stb  = r_fall;
    assign io_bus.o_cfg_err   = r_err;
endmodule

// File: tb/tb_prog_clk_div.sv
// Directed bench for prog_clk_div: waveform shape, reconfiguration, errors, freeze, sync, reset.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: checks o_cfg_ready around config accept/apply.
module tb_prog_clk_div;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic m_prev = 1'b0;

    prog_clk_div_if #(.CNT_WID(CW)) bus ();

    prog_clk_div #(
        .CNT_WID        (CW),
        .DEFAULT_PERIOD (8),
        .DEFAULT_HIGH   (4)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected waveform: count starts at c0 after the next edge and wraps at per.
    task automatic check_wave(input string tag, input int n, input int c0, input int per, input int hi);
        for (int i = 0; i < n; i++) begin
            logic e;
            tick();
            e = (((c0 + i) % per) < hi);
            chk($sformatf("%s.clk[%0d]", tag, i), 32'(bus.o_clk), 32'(e));
            chk($sformatf("%s.rise[%0d]", tag, i), 32'(bus.o_rise_stb), 32'(e & !m_prev));
            chk($sformatf("%s.fall[%0d]", tag, i), 32'(bus.o_fall_stb), 32'(!e & m_prev));
            m_prev = e;
        end
    endtask

    task automatic check_hold(input string tag, input int n, input logic exp_clk);
        for (int i = 0; i < n; i++) begin
            tick();
            chk($sformatf("%s.clk[%0d]", tag, i), 32'(bus.o_clk), 32'(exp_clk));
            chk($sformatf("%s.rise[%0d]", tag, i), 32'(bus.o_rise_stb), 32'd0);
            chk($sformatf("%s.fall[%0d]", tag, i), 32'(bus.o_fall_stb), 32'd0);
        end
    endtask

    task automatic cfg(input logic v, input int per, input int hi);
        bus.i_cfg_valid  = v;
        bus.i_cfg_period = CW'(per);
        bus.i_cfg_high   = CW'(hi);
    endtask

    initial begin
        bus.i_ce = 1'b0;
        bus.i_sync = 1'b0;
        cfg(1'b0, 0, 0);

        // Reset values
        tick();
        tick();
        chk("rst.clk", 32'(bus.o_clk), 32'd0);
        chk("rst.rise", 32'(bus.o_rise_stb), 32'd0);
        chk("rst.fall", 32'(bus.o_fall_stb), 32'd0);
        chk("rst.err", 32'(bus.o_cfg_err), 32'd0);
        chk("rst.rdy", 32'(bus.o_cfg_ready), 32'd1);
        rst = 1'b0;
        bus.i_ce = 1'b1;

        // Default 4 high / 4 low
        check_wave("dflt", 16, 0, 8, 4);

        // Reconfigure to 5/2 mid-period; old period completes first
        check_wave("pre", 3, 0, 8, 4);
        cfg(1'b1, 5, 2);
        check_wave("acc", 1, 3, 8, 4);
        cfg(1'b0, 0, 0);
        chk("acc.rdy", 32'(bus.o_cfg_ready), 32'd0);
        check_wave("old", 4, 4, 8, 4);
        chk("old.rdy", 32'(bus.o_cfg_ready), 32'd0);
        check_wave("new0", 1, 0, 5, 2);
        chk("new.rdy", 32'(bus.o_cfg_ready), 32'd1);
        check_wave("new", 9, 1, 5, 2);

        // Rejected configs
        cfg(1'b1, 1, 0);
        check_wave("bad1", 1, 0, 5, 2);
        chk("bad1.err", 32'(bus.o_cfg_err), 32'd1);
        chk("bad1.rdy", 32'(bus.o_cfg_ready), 32'd1);
        cfg(1'b0, 0, 0);
        check_wave("bad1b", 1, 1, 5, 2);
        chk("bad1b.err", 32'(bus.o_cfg_err), 32'd0);
        cfg(1'b1, 4, 6);
        check_wave("bad2", 1, 2, 5, 2);
        chk("bad2.err", 32'(bus.o_cfg_err), 32'd1);
        chk("bad2.rdy", 32'(bus.o_cfg_ready), 32'd1);
        cfg(1'b0, 0, 0);
        check_wave("bad2b", 5, 3, 5, 2);
        chk("bad2b.err", 32'(bus.o_cfg_err), 32'd0);

        // Back to 8/4, then freeze at cnt=2 for 7 cycles
        cfg(1'b1, 8, 4);
        check_wave("r84a", 1, 3, 5, 2);
        cfg(1'b0, 0, 0);
        check_wave("r84b", 1, 4, 5, 2);
        check_wave("r84c", 3, 0, 8, 4);
        bus.i_ce = 1'b0;
        check_hold("frz", 7, 1'b1);
        bus.i_ce = 1'b1;
        check_wave("resume", 6, 3, 8, 4);

        // Sync at cnt=5 with pending 6/3
        cfg(1'b1, 6, 3);
        check_wave("spre", 1, 1, 8, 4);
        cfg(1'b0, 0, 0);
        check_wave("spre2", 4, 2, 8, 4);
        chk("spre.rdy", 32'(bus.o_cfg_ready), 32'd0);
        bus.i_sync = 1'b1;
        check_wave("sync", 1, 0, 6, 3);
        bus.i_sync = 1'b0;
        chk("sync.rdy", 32'(bus.o_cfg_ready), 32'd1);
        check_wave("post", 7, 1, 6, 3);

        // i_ce low beats i_sync
        bus.i_ce = 1'b0;
        bus.i_sync = 1'b1;
        check_hold("cesync", 1, 1'b1);
        bus.i_ce = 1'b1;
        bus.i_sync = 1'b0;
        cfg(1'b1, 10, 7);
        check_wave("cesync2", 1, 2, 6, 3);
        cfg(1'b0, 0, 0);
        chk("pend.rdy", 32'(bus.o_cfg_ready), 32'd0);

        // Reset mid-high with pending config
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2.clk", 32'(bus.o_clk), 32'd0);
        chk("rst2.rise", 32'(bus.o_rise_stb), 32'd0);
        chk("rst2.fall", 32'(bus.o_fall_stb), 32'd0);
        chk("rst2.rdy", 32'(bus.o_cfg_ready), 32'd1);
        m_prev = 1'b0;
        check_wave("rst2", 9, 0, 8, 4);

        // high=0: constant low
        cfg(1'b1, 4, 0);
        check_wave("h0a", 1, 1, 8, 4);
        cfg(1'b0, 0, 0);
        check_wave("h0b", 6, 2, 8, 4);
        check_wave("h0", 8, 0, 4, 0);

        // high=period: constant high, one rise
        cfg(1'b1, 3, 3);
        check_wave("hfa", 1, 0, 4, 0);
        cfg(1'b0, 0, 0);
        check_wave("hfb", 3, 1, 4, 0);
        check_wave("hf", 6, 0, 3, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
